// File: rtl/uart_tx_framer.sv
// UART transmit framer: serialises start, DATA_W data bits (LSB first), optional
// parity and STOP_BITS stop bits onto tx, each bit lasting a latched baud divisor.
//
// state  | meaning
// IDLE   | line high, tx_rdy=1, waiting for load
// START  | start bit (tx=0)
// DATA   | data bits, LSB first, bit_cnt tracks position
// PARITY | parity bit (only when latched parity_en=1)
// STOP   | stop bit(s), tx=1, stop_cnt tracks remaining
module uart_tx_framer #(
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1,
    parameter int DIV_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              parity_en,
    input  logic              odd_n_even,
    input  logic [DIV_W-1:0]  baud_div,
    output logic              tx,
    output logic              tx_rdy,
    output logic              tx_done
);

    localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic              par_en_q;
    logic              par_q;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  baud_cnt;
    logic [BCW-1:0]    bit_cnt;
    logic              stop_cnt;
    logic [DIV_W-1:0]  div_in;
    logic              bit_end;

    assign div_in  = (baud_div == '0) ? DIV_W'(1) : baud_div;
    assign bit_end = (baud_cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            shreg    <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            div_q    <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            tx       <= 1'b1;
            tx_rdy   <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            // Baud down-counter reloads at every bit boundary while framing.
            if (state != IDLE)
                baud_cnt <= bit_end ? (div_q - DIV_W'(1)) : (baud_cnt - DIV_W'(1));

            case (state)
                IDLE: begin
                    if (load) begin
                        shreg    <= load_data;
                        par_en_q <= parity_en;
                        par_q    <= (^load_data) ^ odd_n_even;
                        div_q    <= div_in;
                        baud_cnt <= div_in - DIV_W'(1);
                        tx       <= 1'b0;
                        tx_rdy   <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == BCW'(DATA_W - 1)) begin
                            if (par_en_q) begin
                                tx    <= par_q;
                                state <= PARITY;
                            end else begin
                                tx       <= 1'b1;
                                stop_cnt <= 1'(STOP_BITS - 1);
                                state    <= STOP;
                            end
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + BCW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        tx       <= 1'b1;
                        stop_cnt <= 1'(STOP_BITS - 1);
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (stop_cnt == 1'b0) begin
                            tx      <= 1'b1;
                            tx_rdy  <= 1'b1;
                            tx_done <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            stop_cnt <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: an 8N1-style instance and a 9-bit/2-stop instance,
// each frame checked cycle by cycle against a bench-side bit sequence.
module tb_uart_tx_framer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load1, load2;
    logic [7:0]  ld8;
    logic [8:0]  ld9;
    logic        parity_en, odd_n_even;
    logic [15:0] baud_div;
    logic        tx1, rdy1, done1;
    logic        tx2, rdy2, done2;

    int tests    = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_framer #(.DATA_W(8), .STOP_BITS(1), .DIV_W(16)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .load(load1), .load_data(ld8),
        .parity_en(parity_en), .odd_n_even(odd_n_even), .baud_div(baud_div),
        .tx(tx1), .tx_rdy(rdy1), .tx_done(done1)
    );

    uart_tx_framer #(.DATA_W(9), .STOP_BITS(2), .DIV_W(16)) u_dut9 (
        .clk(clk), .reset_n(reset_n), .load(load2), .load_data(ld9),
        .parity_en(parity_en), .odd_n_even(odd_n_even), .baud_div(baud_div),
        .tx(tx2), .tx_rdy(rdy2), .tx_done(done2)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic start_frame(input int which, input logic [8:0] data, input bit pen,
                               input bit odd, input logic [15:0] bd);
        @(negedge clk);
        ld8        = data[7:0];
        ld9        = data;
        parity_en  = pen;
        odd_n_even = odd;
        baud_div   = bd;
        if (which == 1) load2 = 1'b1;
        else            load1 = 1'b1;
        @(posedge clk);
    endtask

    // Called right after the accepting edge; returns at the negedge where tx_done shows.
    task automatic check_frame(input int which, input logic [8:0] data, input int dw,
                               input int sb, input bit pen, input bit odd, input int div,
                               input bit hold, input int disturb_at, input int exp_cycles,
                               input string name);
        int       nbits, total, low_cnt, b;
        logic     par, exp_bit;
        logic [2:0] obs;
        par = odd;
        for (int k = 0; k < dw; k++) par = par ^ data[k];
        nbits   = 1 + dw + (pen ? 1 : 0) + sb;
        total   = nbits * div;
        low_cnt = 0;
        for (int i = 1; i <= total; i++) begin
            @(negedge clk);
            if (i == 1 && !hold) begin load1 = 1'b0; load2 = 1'b0; end
            if (disturb_at != 0 && i == disturb_at) begin
                ld8 = 8'hAA; ld9 = 9'h0AA; baud_div = 16'd9;
                parity_en = ~pen; odd_n_even = ~odd;
                if (which == 1) load2 = 1'b1;
                else            load1 = 1'b1;
            end
            if (disturb_at != 0 && i == disturb_at + 1) begin load1 = 1'b0; load2 = 1'b0; end
            b = (i - 1) / div;
            if (b == 0)                   exp_bit = 1'b0;
            else if (b <= dw)             exp_bit = data[b-1];
            else if (pen && b == dw + 1)  exp_bit = par;
            else                          exp_bit = 1'b1;
            obs = (which == 1) ? {tx2, rdy2, done2} : {tx1, rdy1, done1};
            if (!obs[1]) low_cnt++;
            tests++;
            if (obs !== {exp_bit, 2'b00}) begin
                failures++;
                $display("FAIL %s bit %0d cycle %0d: tx/rdy/done=%b expected %b",
                         name, b, i, obs, {exp_bit, 2'b00});
            end
        end
        @(negedge clk);
        obs = (which == 1) ? {tx2, rdy2, done2} : {tx1, rdy1, done1};
        tests++;
        if (obs !== 3'b111) begin
            failures++;
            $display("FAIL %s end: tx/rdy/done=%b expected 111", name, obs);
        end
        tests++;
        if (low_cnt !== exp_cycles) begin
            failures++;
            $display("FAIL %s rdy_low: %0d cycles expected %0d", name, low_cnt, exp_cycles);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; load1 = 1'b0; load2 = 1'b0;
        ld8 = '0; ld9 = '0; parity_en = 1'b0; odd_n_even = 1'b0; baud_div = 16'd4;
        #12;
        tests++;
        if ({tx1, rdy1, done1, tx2, rdy2, done2} !== 6'b110110) begin
            failures++;
            $display("FAIL reset: outputs=%b expected 110110",
                     {tx1, rdy1, done1, tx2, rdy2, done2});
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        tests++;
        if ({tx1, rdy1, done1} !== 3'b110) begin
            failures++;
            $display("FAIL idle_after_reset: outputs=%b expected 110", {tx1, rdy1, done1});
        end
    endtask

    task automatic test_basic;
        start_frame(0, 9'h00F, 1'b1, 1'b0, 16'd4);
        check_frame(0, 9'h00F, 8, 1, 1'b1, 1'b0, 4, 1'b0, 0, 44, "basic_0F_even");
        @(negedge clk);
        tests++;
        if (done1 !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse_width: tx_done=%b expected 0", done1);
        end
    endtask

    task automatic test_parity_sweep;
        logic [8:0] d;
        for (int di = 0; di < 2; di++) begin
            d = (di == 0) ? 9'h00F : 9'h007;
            for (int m = 0; m < 4; m++) begin
                start_frame(0, d, m[1], m[0], 16'd4);
                check_frame(0, d, 8, 1, m[1], m[0], 4, 1'b0, 0, m[1] ? 44 : 40, "parity_sweep");
            end
        end
    endtask

    task automatic test_midframe_ignore;
        start_frame(0, 9'h00F, 1'b0, 1'b0, 16'd4);
        check_frame(0, 9'h00F, 8, 1, 1'b0, 1'b0, 4, 1'b0, 10, 40, "midframe_load_div");
        start_frame(0, 9'h0C5, 1'b0, 1'b0, 16'd9);
        check_frame(0, 9'h0C5, 8, 1, 1'b0, 1'b0, 9, 1'b0, 0, 90, "next_frame_div9");
    endtask

    task automatic test_back_to_back;
        start_frame(0, 9'h00F, 1'b1, 1'b1, 16'd2);
        check_frame(0, 9'h00F, 8, 1, 1'b1, 1'b1, 2, 1'b1, 0, 22, "b2b_first");
        ld8 = 8'h96; ld9 = 9'h096;
        @(posedge clk);
        check_frame(0, 9'h096, 8, 1, 1'b1, 1'b1, 2, 1'b0, 0, 22, "b2b_second");
    endtask

    task automatic test_div_zero;
        start_frame(0, 9'h03C, 1'b1, 1'b0, 16'd0);
        check_frame(0, 9'h03C, 8, 1, 1'b1, 1'b0, 1, 1'b0, 0, 11, "div_zero");
    endtask

    task automatic test_async_reset;
        start_frame(0, 9'h053, 1'b1, 1'b0, 16'd4);
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            if (i == 1) load1 = 1'b0;
        end
        #1 reset_n = 1'b0;
        #1;
        tests++;
        if ({tx1, rdy1, done1} !== 3'b110) begin
            failures++;
            $display("FAIL async_reset: tx/rdy/done=%b expected 110", {tx1, rdy1, done1});
        end
        @(negedge clk);
        reset_n = 1'b1;
        start_frame(0, 9'h053, 1'b1, 1'b0, 16'd4);
        check_frame(0, 9'h053, 8, 1, 1'b1, 1'b0, 4, 1'b0, 0, 44, "after_reset");
    endtask

    task automatic test_wide;
        start_frame(1, 9'h1FF, 1'b1, 1'b0, 16'd3);
        check_frame(1, 9'h1FF, 9, 2, 1'b1, 1'b0, 3, 1'b0, 0, 39, "wide_1FF_even");
        start_frame(1, 9'h0A5, 1'b0, 1'b1, 16'd2);
        check_frame(1, 9'h0A5, 9, 2, 1'b0, 1'b1, 2, 1'b0, 0, 24, "wide_0A5_nopar");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity_sweep();
        test_midframe_ignore();
        test_back_to_back();
        test_div_zero();
        test_async_reset();
        test_wide();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
